// File: rtl/rr_encoder_4_2_pkg.sv
// Shared constants and types for the round-robin 4-to-2 encoder.
// Imported by the pick sub-module and the top level.
package rr_encoder_4_2_pkg;

    localparam int REQ_W = 4;
    localparam int IDX_W = 2;

    typedef enum logic {
        RR_OFF = 1'b0,
        RR_ON  = 1'b1
    } rr_mode_e;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/rr_encoder_4_2_pick.sv
// Combinational rotating-priority pick: rotate by base, fixed pick, rotate back.
// Also reports whether any and more than one request is set.
module rr_pick_4
    import rr_encoder_4_2_pkg::*;
(
    input  logic [REQ_W-1:0] req,
    input  logic [IDX_W-1:0] base,
    output logic [IDX_W-1:0] sel,
    output logic             any,
    output logic             multi
);

    logic [2*REQ_W-1:0] dbl;
    logic [REQ_W-1:0]   rot;
    logic [IDX_W-1:0]   pick;
    logic [2:0]         cnt;

    assign dbl = {req, req} >> base;
    assign rot = dbl[REQ_W-1:0];

    // fixed priority on the rotated vector, bit 0 highest
    always_comb begin
        pick = 2'd0;
        if (rot[0])      pick = 2'd0;
        else if (rot[1]) pick = 2'd1;
        else if (rot[2]) pick = 2'd2;
        else if (rot[3]) pick = 2'd3;
    end

    // population count of the raw request vector
    always_comb begin
        cnt = 3'd0;
        for (int i = 0; i < REQ_W; i++) begin
            cnt = cnt + {2'b00, req[i]};
        end
    end

    assign sel   = pick + base;
    assign any   = |req;
    assign multi = (cnt > 3'd1);

endmodule

// File: rtl/rr_encoder_4_2.sv
// Registered 4-to-2 round-robin encoder with valid/ready output.
// Holds the output registers, the handshake state and the priority pointer.
module rr_encoder_4_2
    import rr_encoder_4_2_pkg::*;
#(
    parameter int RR       = 1,
    parameter int HOLD_REQ = 0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [REQ_W-1:0] req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [REQ_W-1:0] out_onehot,
    output logic             out_multi
);

    localparam rr_mode_e MODE = (RR != 0) ? RR_ON : RR_OFF;
    localparam logic     HOLD = (HOLD_REQ != 0);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [REQ_W-1:0] oh_q, oh_d;
    logic             multi_q, multi_d;

    logic             accept;
    logic             drop;
    logic [IDX_W-1:0] sel;
    logic             any;
    logic             multi;

    assign out_valid  = (state_q == FULL);
    assign out_idx    = idx_q;
    assign out_onehot = oh_q;
    assign out_multi  = multi_q;

    assign accept = out_valid && out_ready;
    assign ptr_d  = (accept && MODE == RR_ON) ? idx_q + 2'd1 : ptr_q;

    // a granted requester that let go is withdrawn unless already taken
    assign drop = HOLD && out_valid && !accept && !req[idx_q];

    rr_pick_4 u_pick (
        .req   (req),
        .base  (ptr_d),
        .sel   (sel),
        .any   (any),
        .multi (multi)
    );

    // state register, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            idx_q   <= '0;
            oh_q    <= '0;
            multi_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            oh_q    <= oh_d;
            multi_q <= multi_d;
        end
    end

    // next state: capture on load, otherwise hold or withdraw
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        oh_d    = oh_q;
        multi_d = multi_q;
        unique case (state_q)
            EMPTY, FULL: begin
                if (state_q == EMPTY || accept) begin
                    if (any) begin
                        state_d = FULL;
                        idx_d   = sel;
                        oh_d    = 4'b0001 << sel;
                        multi_d = multi;
                    end else begin
                        state_d = EMPTY;
                        oh_d    = '0;
                        multi_d = 1'b0;
                    end
                end else if (drop) begin
                    state_d = EMPTY;
                    oh_d    = '0;
                    multi_d = 1'b0;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

endmodule

// File: tb/tb_rr_encoder_4_2.sv
// Directed bench for rr_encoder_4_2 with a queue scoreboard.
// Three instances: round-robin, fixed priority, round-robin with HOLD_REQ.
module tb_rr_encoder_4_2;

    logic       clk = 1'b0;
    logic       resetn;
    logic [3:0] req;
    logic       out_ready;

    logic       v0, v1, v2;
    logic [1:0] i0, i1, i2;
    logic [3:0] o0, o1, o2;
    logic       m0, m1, m2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         dut;
        logic [7:0] val;
        string      tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    rr_encoder_4_2 #(.RR(1), .HOLD_REQ(0)) u_rr (
        .clk(clk), .resetn(resetn), .req(req),
        .out_valid(v0), .out_ready(out_ready),
        .out_idx(i0), .out_onehot(o0), .out_multi(m0)
    );

    rr_encoder_4_2 #(.RR(0), .HOLD_REQ(0)) u_fp (
        .clk(clk), .resetn(resetn), .req(req),
        .out_valid(v1), .out_ready(out_ready),
        .out_idx(i1), .out_onehot(o1), .out_multi(m1)
    );

    rr_encoder_4_2 #(.RR(1), .HOLD_REQ(1)) u_hr (
        .clk(clk), .resetn(resetn), .req(req),
        .out_valid(v2), .out_ready(out_ready),
        .out_idx(i2), .out_onehot(o2), .out_multi(m2)
    );

    function automatic logic [7:0] obs(int d);
        case (d)
            0:       return {v0, i0, o0, m0};
            1:       return {v1, i1, o1, m1};
            default: return {v2, i2, o2, m2};
        endcase
    endfunction

    task automatic expect_out(input int d, input logic v, input logic [1:0] idx,
                              input logic [3:0] oh, input logic m, input string tag);
        exp_t e;
        e.dut = d;
        e.val = {v, idx, oh, m};
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        logic [7:0] got;
        @(posedge clk);
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            got = obs(e.dut);
            checks++;
            assert (got === e.val) else begin
                errors++;
                $error("FAIL %s dut%0d got v/idx/oh/m=%b exp %b",
                       e.tag, e.dut, got, e.val);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        resetn = 1'b0;
        req = 4'b1111;
        out_ready = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 2; k++) begin
            for (int d = 0; d < 3; d++) expect_out(d, 0, 2'd0, 4'b0000, 0, "reset");
            tick();
        end

        resetn = 1'b1;
        out_ready = 1'b1;
        for (int d = 0; d < 3; d++) expect_out(d, 1, 2'd0, 4'b0001, 1, "first");
        tick();

        expect_out(0, 1, 2'd1, 4'b0010, 1, "rot1");
        expect_out(1, 1, 2'd0, 4'b0001, 1, "fp_rot");
        expect_out(2, 1, 2'd1, 4'b0010, 1, "hr_rot1");
        tick();
        expect_out(0, 1, 2'd2, 4'b0100, 1, "rot2");
        expect_out(2, 1, 2'd2, 4'b0100, 1, "hr_rot2");
        tick();
        expect_out(0, 1, 2'd3, 4'b1000, 1, "rot3");
        expect_out(2, 1, 2'd3, 4'b1000, 1, "hr_rot3");
        tick();
        expect_out(0, 1, 2'd0, 4'b0001, 1, "rot0");
        tick();
        expect_out(0, 1, 2'd1, 4'b0010, 1, "rot1b");
        tick();
        expect_out(0, 1, 2'd2, 4'b0100, 1, "rot2b");
        tick();

        req = 4'b0011;
        expect_out(0, 1, 2'd0, 4'b0001, 1, "wrap0");
        expect_out(1, 1, 2'd0, 4'b0001, 1, "fp_wrap");
        tick();
        expect_out(0, 1, 2'd1, 4'b0010, 1, "wrap1");
        tick();
        expect_out(0, 1, 2'd0, 4'b0001, 1, "wrap0b");
        tick();

        req = 4'b0100;
        expect_out(0, 1, 2'd2, 4'b0100, 0, "bp_cap");
        expect_out(1, 1, 2'd2, 4'b0100, 0, "fp_bp_cap");
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 1) req = 4'b1000;
            expect_out(0, 1, 2'd2, 4'b0100, 0, "bp_hold");
            expect_out(1, 1, 2'd2, 4'b0100, 0, "fp_bp_hold");
            tick();
        end
        out_ready = 1'b1;
        expect_out(0, 1, 2'd3, 4'b1000, 0, "bp_next");
        expect_out(1, 1, 2'd3, 4'b1000, 0, "fp_single3");
        tick();

        req = 4'b1010;
        expect_out(0, 1, 2'd1, 4'b0010, 1, "rr_1010a");
        expect_out(1, 1, 2'd1, 4'b0010, 1, "fp_1010a");
        tick();
        expect_out(0, 1, 2'd3, 4'b1000, 1, "rr_1010b");
        expect_out(1, 1, 2'd1, 4'b0010, 1, "fp_1010b");
        tick();
        expect_out(0, 1, 2'd1, 4'b0010, 1, "rr_1010c");
        expect_out(1, 1, 2'd1, 4'b0010, 1, "fp_1010c");
        tick();

        req = 4'b0000;
        expect_out(0, 0, 2'd1, 4'b0000, 0, "idle_drop");
        expect_out(1, 0, 2'd1, 4'b0000, 0, "fp_idle");
        tick();
        expect_out(0, 0, 2'd1, 4'b0000, 0, "idle_stay");
        tick();
        req = 4'b1111;
        out_ready = 1'b0;
        expect_out(0, 1, 2'd2, 4'b0100, 1, "idle_resume");
        tick();

        resetn = 1'b0;
        for (int d = 0; d < 3; d++) expect_out(d, 0, 2'd0, 4'b0000, 0, "reset_mid");
        tick();
        resetn = 1'b1;
        req = 4'b0100;
        expect_out(2, 1, 2'd2, 4'b0100, 0, "hr_cap");
        expect_out(0, 1, 2'd2, 4'b0100, 0, "rr_cap2");
        tick();
        req = 4'b0000;
        expect_out(2, 0, 2'd2, 4'b0000, 0, "hr_drop");
        expect_out(0, 1, 2'd2, 4'b0100, 0, "rr_nodrop");
        tick();
        req = 4'b1111;
        expect_out(2, 1, 2'd0, 4'b0001, 1, "hr_ptr_kept");
        expect_out(0, 1, 2'd2, 4'b0100, 0, "rr_still");
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_encoder_4_2.md
Name: rr_encoder_4_2

Overview:
- Registered 4-to-2 encoder with rotating (round-robin) priority and a valid/ready output handshake.
- Converts a 4-bit request vector into a 2-bit index, a matching one-hot grant, and a multi-request flag.
- Sits in lib/ and serves as the encode-side counterpart to the 2-to-4 one-hot decoding used in datapath select logic.
- Used wherever several requesters share one resource and the consumer needs a binary select (e.g. bus/port arbitration feeding a mux select).

Parameters:
- RR, 1, 1 = round-robin priority rotation; 0 = fixed priority (bit 0 highest), pointer held at 0.
- HOLD_REQ, 0, 1 = re-check that the granted request is still asserted before output (drop the grant if deasserted); 0 = grant latched regardless.

Ports:
- clk  input  1  system clock, all state on rising edge.
- resetn  input  1  synchronous reset, active-low.
- req  input  4  request vector, bit i = requester i.
- out_valid  output  1  registered index is valid.
- out_ready  input  1  consumer accepts the index when out_valid && out_ready.
- out_idx  output  2  encoded index of the granted requester.
- out_onehot  output  4  one-hot of out_idx; 4'b0000 when out_valid=0.
- out_multi  output  1  more than one req bit was set when out_idx was captured.

Behaviour:
- Clock and reset: single clock clk; reset resetn is synchronous and active-low.
- Reset values (resetn=0 at a rising edge): out_valid=0, out_idx=2'b00, out_onehot=4'b0000, out_multi=0, internal pointer ptr=2'b00. Reset overrides all other events, including a pending accept.
- State per valid bit:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- Load condition: load = !out_valid || (out_valid && out_ready).
- Priority base:
  - base = ptr_next, where ptr_next = (accept && RR) ? out_idx+1 (mod 4) : ptr.
  - ptr <= ptr_next every cycle.
  - With RR=0, ptr stays 2'b00 permanently.
- Selection: the first set bit of req scanning base, base+1, base+2, base+3 (mod 4, wrap-around from 3 to 0).
- On load with req != 0: out_valid<=1; out_idx<=selected; out_onehot<=1<<selected; out_multi<=(popcount(req)>1).
- On load with req == 0: out_valid<=0; out_onehot<=0; out_multi<=0; out_idx holds its previous value.
- Latency: 1 cycle from req sampled to out_valid.
- Back-to-back: an accept and a new capture occur in the same cycle, giving one grant per cycle when out_ready is held high.
- FULL without accept: all outputs hold stable; changes on req are ignored (no output glitch).
- HOLD_REQ=1: while FULL and req[out_idx]=0, the next edge clears out_valid (to EMPTY) without advancing ptr.
- No combinational path from req to any output; out_ready affects only next-state.
- out_ready while EMPTY is ignored.
- Reset mid-operation: an outstanding grant is discarded, and rotation restarts at bit 0.

Decomposition:
- Shared defines header:
  - REQ_W=4 and IDX_W=2 constants.
  - Priority-mode encodings RR_ON/RR_OFF.
- One sub-module, rr_pick_4: combinational; inputs req[3:0] and base[1:0]; outputs sel[1:0], any, multi. It does a rotate right by base, a fixed priority pick, then adds base back (mod 4).
- The top level holds the registers, the handshake and the pointer.

Test Plan:
- Reset: hold resetn=0 with req=4'b1111 for 2 cycles -> out_valid=0, out_onehot=0, out_idx=0, out_multi=0. First edge after release -> out_idx=0, out_onehot=4'b0001, out_multi=1.
- Rotation: req=4'b1111 constant, out_ready=1, RR=1 -> out_idx sequence 0,1,2,3,0 on consecutive cycles, out_onehot 0001,0010,0100,1000,0001.
- Sparse wrap: ptr=3 (after granting 2), req=4'b0011 -> out_idx=0, next grant out_idx=1, then 0 again; out_multi=1 on each.
- Backpressure: req=4'b0100, out_ready=0 for 5 cycles and req changed to 4'b1000 at cycle 2 -> out_idx stays 2, out_onehot=0100, out_valid=1. After out_ready=1 for one cycle, next out_idx=3.
- Fixed priority: RR=0, req=4'b1010, out_ready=1 -> out_idx=1 every cycle, never 3. With req=4'b1000 -> out_idx=3, out_multi=0.
- Idle and HOLD_REQ: req=0 -> out_valid drops to 0 one cycle after the accept. With HOLD_REQ=1, grant 2 pending and out_ready=0, req[2]->0 -> out_valid=0 next cycle and ptr unchanged (next req=4'b1111 gives out_idx=0 at reset state).
